// File: rtl/round_key_sequencer.sv
// rtl/round_key_sequencer.sv - streams a latched bundle of round keys, one per handshake, in forward or reverse order
module round_key_sequencer #(
    parameter int KEY_W      = 128,
    parameter int NUM_ROUNDS = 10,
    parameter int IDX_W      = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            dec_mode,
    input  logic                            abort,
    input  logic [(NUM_ROUNDS+1)*KEY_W-1:0] key_bundle,
    input  logic                            rk_ready,
    output logic                            rk_valid,
    output logic [KEY_W-1:0]                rk_data,
    output logic [IDX_W-1:0]                rk_index,
    output logic                            rk_first,
    output logic                            rk_last,
    output logic                            busy,
    output logic                            done
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROUNDS);

    state_t                          state_q;
    logic [(NUM_ROUNDS+1)*KEY_W-1:0] bundle_q;
    logic                            dec_q;
    logic                            valid_q;
    logic                            first_q;
    logic                            last_q;
    logic                            busy_q;
    logic                            done_q;
    logic [KEY_W-1:0]                data_q;
    logic [IDX_W-1:0]                idx_q;

    logic [IDX_W-1:0] first_idx;
    logic [IDX_W-1:0] term_idx;
    logic [IDX_W-1:0] idx_d;

    // Key k lives at the MSB end for k = 0; an explicit mux keeps unused index codes harmless.
    function automatic logic [KEY_W-1:0] key_at(input logic [IDX_W-1:0] i);
        key_at = '0;
        for (int k = 0; k <= NUM_ROUNDS; k++) begin
            if (i == IDX_W'(k)) begin
                key_at = bundle_q[(NUM_ROUNDS-k)*KEY_W +: KEY_W];
            end
        end
    endfunction

    always_comb begin
        first_idx = dec_q ? LAST_IDX : '0;
        term_idx  = dec_q ? '0 : LAST_IDX;
        idx_d     = dec_q ? idx_q - IDX_W'(1) : idx_q + IDX_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            bundle_q <= '0;
            dec_q    <= 1'b0;
            valid_q  <= 1'b0;
            first_q  <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            data_q   <= '0;
            idx_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        bundle_q <= key_bundle;
                        dec_q    <= dec_mode;
                        busy_q   <= 1'b1;
                        state_q  <= LOAD;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        valid_q <= 1'b1;
                        first_q <= 1'b1;
                        last_q  <= (first_idx == term_idx);
                        idx_q   <= first_idx;
                        data_q  <= key_at(first_idx);
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    // Abort wins over a transfer happening on the same edge.
                    if (abort) begin
                        valid_q <= 1'b0;
                        first_q <= 1'b0;
                        last_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (valid_q && rk_ready) begin
                        if (last_q) begin
                            valid_q <= 1'b0;
                            first_q <= 1'b0;
                            last_q  <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            first_q <= 1'b0;
                            last_q  <= (idx_d == term_idx);
                            idx_q   <= idx_d;
                            data_q  <= key_at(idx_d);
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rk_valid = valid_q;
    assign rk_data  = data_q;
    assign rk_index = idx_q;
    assign rk_first = first_q;
    assign rk_last  = last_q;
    assign busy     = busy_q;
    assign done     = done_q;
endmodule
